add16u_err_monitor: RTL and testbench

//  Streaming error monitor sitting directly downstream of an approximate 16-bit unsigned adder.

---
 rtl/add16u_err_pkg.sv | 27 ++
 rtl/add16u_err_absdiff.sv | 49 ++++
 rtl/add16u_err_monitor.sv | 129 ++++++++++++
 tb/tb_add16u_err_monitor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add16u_err_pkg.sv
// Shared definitions for the approximate-adder error monitor.
//   state_t      : run-control FSM states
//   ADD_W        : default operand width
//   CNT_W_DEF    : default sample-counter width
//   acc_width()  : err_sum width that cannot overflow for a full-length run
//   sq_width()   : err_sq width that cannot overflow for a full-length run
package add16u_err_pkg;

    localparam int unsigned ADD_W     = 16;
    localparam int unsigned CNT_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned acc_width(input int unsigned w, input int unsigned cnt_w);
        return w + 1 + cnt_w;
    endfunction

    function automatic int unsigned sq_width(input int unsigned w, input int unsigned cnt_w);
        return 2 * (w + 1) + cnt_w;
    endfunction

endpackage

// File: rtl/add16u_err_absdiff.sv
// First pipeline stage of the error monitor: recomputes the exact sum of the
// operands and registers the absolute error against the approximate sum.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears s1_valid)
//   in_valid   : an accepted sample is present on in_a/in_b/in_o
//   in_a, in_b : operands (W bits)
//   in_o       : approximate sum under test (W+1 bits)
//   s1_valid   : registered sample valid
//   s1_abs     : registered |(in_a+in_b) - in_o|
//   s1_nz      : registered (error != 0)
module add16u_err_absdiff
    import add16u_err_pkg::*;
#(
    parameter int unsigned W = ADD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W:0]   in_o,
    output logic         s1_valid,
    output logic [W:0]   s1_abs,
    output logic         s1_nz
);

    logic [W:0] exact;
    logic [W:0] diff_abs;

    // Unsigned magnitude without a sign bit: subtract the smaller from the larger.
    always_comb begin
        exact    = {1'b0, in_a} + {1'b0, in_b};
        diff_abs = (exact >= in_o) ? (exact - in_o) : (in_o - exact);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        s1_abs <= diff_abs;
        s1_nz  <= (exact != in_o);
    end

endmodule

// File: rtl/add16u_err_monitor.sv
// Streaming error monitor for an approximate W-bit unsigned adder.
// Accumulates sum|err|, sum err^2, max|err| and count(err!=0) over a
// programmed number of samples.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a run (honoured only in IDLE/DONE)
//   n_samples   : run length, latched when start is honoured
//   in_valid    : sample valid;  in_ready : sample accepted when both high
//   in_a, in_b  : operands;      in_o     : approximate sum (W+1 bits)
//   busy        : run in progress (accepting samples)
//   done        : run complete, statistics stable
//   sample_cnt  : samples retired this run
//   err_sum     : sum |err|      err_sq  : sum err^2
//   err_max     : max |err|      err_cnt : samples with err != 0
module add16u_err_monitor
    import add16u_err_pkg::*;
#(
    parameter int unsigned W     = ADD_W,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ACC_W = acc_width(W, CNT_W),
    parameter int unsigned SQ_W  = sq_width(W, CNT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [ACC_W-1:0] err_sum,
    output logic [SQ_W-1:0]  err_sq,
    output logic [W:0]       err_max,
    output logic [CNT_W-1:0] err_cnt
);

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] accepted;
    logic             accept;
    logic             start_acc;

    logic             s1_valid;
    logic [W:0]       s1_abs;
    logic             s1_nz;
    logic [SQ_W-1:0]  s1_sq;

    // in_ready depends on registered state only, never on in_valid.
    always_comb begin
        in_ready  = (state == RUN) && (accepted < n_lat);
        accept    = in_valid && in_ready;
        start_acc = start && ((state == IDLE) || (state == DONE));
        busy      = (state == RUN);
        done      = (state == DONE);
        s1_sq     = SQ_W'(s1_abs) * SQ_W'(s1_abs);
    end

    add16u_err_absdiff #(
        .W (W)
    ) u_absdiff (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_o     (in_o),
        .s1_valid (s1_valid),
        .s1_abs   (s1_abs),
        .s1_nz    (s1_nz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            n_lat    <= '0;
            accepted <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_lat    <= n_samples;
                        accepted <= '0;
                        state    <= (n_samples == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        accepted <= accepted + CNT_W'(1);
                        if (accepted + CNT_W'(1) == n_lat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // S2 is the accumulator itself, so only S1 needs to empty.
                    if (!s1_valid) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pipeline is always empty when a start is honoured, so clear and
    // update never coincide.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            sample_cnt <= '0;
            err_sum    <= '0;
            err_sq     <= '0;
            err_max    <= '0;
            err_cnt    <= '0;
        end else if (s1_valid) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            err_sum    <= err_sum + ACC_W'(s1_abs);
            err_sq     <= err_sq + s1_sq;
            if (s1_abs >= err_max) begin
                err_max <= s1_abs;
            end
            err_cnt    <= err_cnt + CNT_W'(s1_nz);
        end
    end

endmodule

// File: tb/tb_add16u_err_monitor.sv
module tb_add16u_err_monitor;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 20;
    localparam int unsigned ACC_W = 37;
    localparam int unsigned SQ_W  = 54;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_samples = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [W:0]       in_o = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [ACC_W-1:0] err_sum;
    logic [SQ_W-1:0]  err_sq;
    logic [W:0]       err_max;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: plain integer statistics over accepted samples.
    longint m_sum, m_sq, m_max, m_cnt, m_n;

    logic [W-1:0] dir_a [3];
    logic [W-1:0] dir_b [3];
    logic [W:0]   dir_o [3];

    add16u_err_monitor #(
        .W     (W),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W),
        .SQ_W  (SQ_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_samples  (n_samples),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_o       (in_o),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt),
        .err_sum    (err_sum),
        .err_sq     (err_sq),
        .err_max    (err_max),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic model_clear();
        m_sum = 0; m_sq = 0; m_max = 0; m_cnt = 0; m_n = 0;
    endtask

    task automatic model_add(input longint a, input longint b, input longint o);
        longint e;
        e = a + b - o;
        if (e < 0) e = -e;
        m_sum += e;
        m_sq  += e * e;
        if (e > m_max) m_max = e;
        if (e != 0) m_cnt++;
        m_n++;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        n_samples = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
    endtask

    // mode 0: exact sums, 1: random errors, 2: directed table
    task automatic feed(input int n, input int gap_pct, input int mode,
                        output int last_acc, output bit timed_out);
        int got;
        int budget;
        bit acc;
        logic [W:0] ex;
        got = 0;
        budget = n * 20 + 50;
        timed_out = 1'b0;
        last_acc = -1;
        while (got < n) begin
            if (budget == 0) begin
                timed_out = 1'b1;
                break;
            end
            budget--;
            if (mode == 2) begin
                in_a = dir_a[got]; in_b = dir_b[got]; in_o = dir_o[got];
            end else begin
                in_a = W'($urandom); in_b = W'($urandom);
                ex = {1'b0, in_a} + {1'b0, in_b};
                if (mode == 0) in_o = ex;
                else begin
                    case ($urandom_range(3))
                        0: in_o = ex;
                        1: in_o = ex ^ (W+1)'($urandom_range(255));
                        2: in_o = (W+1)'($urandom);
                        default: in_o = ex + (W+1)'($urandom_range(15));
                    endcase
                end
            end
            in_valid = ($urandom_range(99) >= gap_pct);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                model_add(longint'(in_a), longint'(in_b), longint'(in_o));
                got++;
                last_acc = cycle;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int done_cyc, output bit timed_out);
        int budget;
        budget = 50;
        timed_out = 1'b0;
        while (!done && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        timed_out = !done;
        done_cyc = cycle;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, done, in_ready} !== 3'b000) begin errors++; $display("FAIL reset_ctrl busy/done/ready got %b exp 000", {busy, done, in_ready}); end
        checks++; if (sample_cnt !== '0 || err_sum !== '0 || err_sq !== '0 || err_max !== '0 || err_cnt !== '0) begin
            errors++; $display("FAIL reset_stats got cnt=%0d sum=%0d sq=%0d max=%0d ecnt=%0d exp all 0", sample_cnt, err_sum, err_sq, err_max, err_cnt);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int la, dc; bit to;
        dir_a[0] = 16'd0;     dir_b[0] = 16'd0;     dir_o[0] = 17'd24;
        dir_a[1] = 16'd5;     dir_b[1] = 16'd6;     dir_o[1] = 17'd3;
        dir_a[2] = 16'd65535; dir_b[2] = 16'd65535; dir_o[2] = 17'd131070;
        do_start(3);
        feed(3, 0, 2, la, to);
        checks++; if (to) begin errors++; $display("FAIL directed_feed timeout got %0d accepts exp 3", m_n); end
        wait_done(dc, to);
        checks++; if (to) begin errors++; $display("FAIL directed_done got done=%b exp 1", done); end
        checks++; if (err_sum !== 37'd32) begin errors++; $display("FAIL directed_sum got %0d exp 32", err_sum); end
        checks++; if (err_sq !== 54'd640) begin errors++; $display("FAIL directed_sq got %0d exp 640", err_sq); end
        checks++; if (err_max !== 17'd24) begin errors++; $display("FAIL directed_max got %0d exp 24", err_max); end
        checks++; if (err_cnt !== 20'd2 || sample_cnt !== 20'd3) begin errors++; $display("FAIL directed_cnt got ecnt=%0d cnt=%0d exp 2 3", err_cnt, sample_cnt); end
    endtask

    task automatic test_zero_n();
        do_start(0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_n_state got done=%b busy=%b exp 1 0", done, busy); end
        checks++; if (sample_cnt !== '0 || err_sum !== '0 || err_sq !== '0 || err_max !== '0 || err_cnt !== '0) begin
            errors++; $display("FAIL zero_n_stats got cnt=%0d sum=%0d sq=%0d max=%0d ecnt=%0d exp all 0", sample_cnt, err_sum, err_sq, err_max, err_cnt);
        end
    endtask

    task automatic test_exact();
        int la, dc; bit to;
        do_start(1000);
        feed(1000, 0, 0, la, to);
        checks++; if (to) begin errors++; $display("FAIL exact_feed timeout got %0d accepts exp 1000", m_n); end
        wait_done(dc, to);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL exact_done got %b exp 1", done); end
        checks++; if (sample_cnt !== 20'd1000) begin errors++; $display("FAIL exact_cnt got %0d exp 1000", sample_cnt); end
        checks++; if (err_sum !== '0 || err_sq !== '0 || err_max !== '0 || err_cnt !== '0) begin
            errors++; $display("FAIL exact_stats got sum=%0d sq=%0d max=%0d ecnt=%0d exp all 0", err_sum, err_sq, err_max, err_cnt);
        end
    endtask

    task automatic test_bursty();
        int la, dc, budget; bit to;
        do_start(16);
        feed(16, 50, 1, la, to);
        checks++; if (to) begin errors++; $display("FAIL bursty_feed timeout got %0d accepts exp 16", m_n); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bursty_ready_drop got %b exp 0", in_ready); end
        // Keep offering samples; none may be counted.
        budget = 20;
        while (!done && budget > 0) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_o = (W+1)'($urandom);
            @(posedge clk); #1;
            budget--;
        end
        in_valid = 1'b0;
        dc = cycle;
        checks++; if (!done || dc != la + 2) begin errors++; $display("FAIL bursty_done_latency got %0d cycles (done=%b) exp 2", dc - la, done); end
        checks++; if (64'(sample_cnt) !== 64'(m_n)) begin errors++; $display("FAIL bursty_cnt got %0d exp %0d", sample_cnt, m_n); end
        checks++; if (64'(err_sum) !== 64'(m_sum) || 64'(err_sq) !== 64'(m_sq)) begin
            errors++; $display("FAIL bursty_sums got sum=%0d sq=%0d exp %0d %0d", err_sum, err_sq, m_sum, m_sq);
        end
        checks++; if (64'(err_max) !== 64'(m_max) || 64'(err_cnt) !== 64'(m_cnt)) begin
            errors++; $display("FAIL bursty_max_cnt got max=%0d ecnt=%0d exp %0d %0d", err_max, err_cnt, m_max, m_cnt);
        end
    endtask

    task automatic test_start_during_run();
        int la, dc; bit to;
        do_start(10);
        feed(4, 0, 1, la, to);
        start = 1'b1; n_samples = 20'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL run_start_ignored got busy=%b done=%b ready=%b exp 1 0 1", busy, done, in_ready);
        end
        checks++; if (sample_cnt !== 20'd4 || 64'(err_sum) !== 64'(m_sum)) begin
            errors++; $display("FAIL run_start_stats got cnt=%0d sum=%0d exp 4 %0d", sample_cnt, err_sum, m_sum);
        end
        feed(6, 20, 1, la, to);
        checks++; if (to) begin errors++; $display("FAIL run_start_feed timeout got %0d accepts exp 10", m_n); end
        wait_done(dc, to);
        checks++; if (!done || sample_cnt !== 20'd10 || 64'(err_sq) !== 64'(m_sq) || 64'(err_max) !== 64'(m_max)) begin
            errors++; $display("FAIL run_start_final got done=%b cnt=%0d sq=%0d max=%0d exp 1 10 %0d %0d", done, sample_cnt, err_sq, err_max, m_sq, m_max);
        end
    endtask

    task automatic test_restart_from_done();
        int la, dc; bit to;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_pre_done got %b exp 1", done); end
        do_start(5);
        checks++; if (busy !== 1'b1 || done !== 1'b0 || sample_cnt !== '0 || err_sum !== '0 || err_sq !== '0 || err_max !== '0 || err_cnt !== '0) begin
            errors++; $display("FAIL restart_clear got busy=%b done=%b cnt=%0d sum=%0d max=%0d exp 1 0 0 0 0", busy, done, sample_cnt, err_sum, err_max);
        end
        feed(5, 0, 1, la, to);
        wait_done(dc, to);
        checks++; if (!done || sample_cnt !== 20'd5 || 64'(err_sum) !== 64'(m_sum) || 64'(err_cnt) !== 64'(m_cnt)) begin
            errors++; $display("FAIL restart_final got done=%b cnt=%0d sum=%0d ecnt=%0d exp 1 5 %0d %0d", done, sample_cnt, err_sum, err_cnt, m_sum, m_cnt);
        end
    endtask

    task automatic test_worst_case();
        int la, dc; bit to;
        dir_a[0] = 16'd0; dir_b[0] = 16'd0; dir_o[0] = 17'd131071;
        do_start(1);
        feed(1, 0, 2, la, to);
        wait_done(dc, to);
        checks++; if (err_max !== 17'd131071) begin errors++; $display("FAIL worst_max got %0d exp 131071", err_max); end
        checks++; if (err_sq !== 54'd17179607041) begin errors++; $display("FAIL worst_sq got %0d exp 17179607041", err_sq); end
        checks++; if (err_sum !== 37'd131071 || err_cnt !== 20'd1) begin errors++; $display("FAIL worst_sum_cnt got %0d %0d exp 131071 1", err_sum, err_cnt); end
    endtask

    task automatic test_mid_run_reset();
        int la, dc; bit to;
        do_start(10);
        feed(5, 0, 1, la, to);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, done, in_ready} !== 3'b000) begin errors++; $display("FAIL midrst_ctrl got busy/done/ready %b exp 000", {busy, done, in_ready}); end
        checks++; if (sample_cnt !== '0 || err_sum !== '0 || err_sq !== '0 || err_max !== '0 || err_cnt !== '0) begin
            errors++; $display("FAIL midrst_stats got cnt=%0d sum=%0d sq=%0d max=%0d ecnt=%0d exp all 0", sample_cnt, err_sum, err_sq, err_max, err_cnt);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(2);
        feed(2, 0, 1, la, to);
        wait_done(dc, to);
        checks++; if (!done || sample_cnt !== 20'd2 || 64'(err_sum) !== 64'(m_sum) || 64'(err_sq) !== 64'(m_sq)) begin
            errors++; $display("FAIL midrst_rerun got done=%b cnt=%0d sum=%0d sq=%0d exp 1 2 %0d %0d", done, sample_cnt, err_sum, err_sq, m_sum, m_sq);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_directed();
        test_zero_n();
        test_exact();
        test_bursty();
        test_start_during_run();
        test_restart_from_done();
        test_worst_case();
        test_mid_run_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
